// File: rtl/frame_pkg.sv
// Shared types and line constants for the frame serializer.
// FRAME_SERIALIZER_PARITY_EN adds the PARITY state to the state enum.
package frame_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef FRAME_SERIALIZER_PARITY_EN
        PARITY,
`endif
        STOP
    } frame_state_t;

    localparam logic LINE_IDLE   = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity over the zero-extended word, inverted when odd is set.
    function automatic logic parity_calc(input logic [31:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/word_hold_buf.sv
// One-entry valid/ready hold register feeding the frame serializer.
// The ready output is registered and always equals the inverse of full.
module word_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             drain,
    output logic             ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    logic             full_reg;
    logic             full_next;
    logic             ready_reg;
    logic [WIDTH-1:0] data_reg;
    logic             accept;

    assign accept = in_valid && ready_reg;

    // Accept and drain never coincide: ready is low whenever there is something to drain.
    always_comb begin
        full_next = full_reg;
        if (accept)
            full_next = 1'b1;
        else if (drain)
            full_next = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full_reg  <= 1'b0;
            ready_reg <= 1'b1;
            data_reg  <= '0;
        end else begin
            full_reg  <= full_next;
            ready_reg <= ~full_next;
            if (accept)
                data_reg <= in_data;
        end
    end

    assign ready = ready_reg;
    assign full  = full_reg;
    assign data  = data_reg;

endmodule

// File: rtl/frame_serializer.sv
// Strobe-paced serial framer: start bit, data LSB-first, optional parity, stop bit(s).
// Define FRAME_SERIALIZER_PARITY_EN to insert a parity bit (PARITY_ODD selects odd parity).
module frame_serializer
    import frame_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1,
`ifdef FRAME_SERIALIZER_PARITY_EN
    parameter bit PARITY_ODD = 1'b0,
`endif
    parameter int CNT_W      = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_strobe,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_valid,
    output logic                  o_ready,
    output logic                  o_bit,
    output logic                  o_bit_valid,
    output logic                  o_busy
);

    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(DATA_WIDTH - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    frame_state_t          state_reg;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0]      bit_cnt_reg;
    logic                  stop_cnt_reg;
    logic                  bit_reg;
    logic                  bit_valid_reg;
    logic                  hold_full;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  load;
    logic                  next_lsb;

    word_hold_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk      (i_clk),
        .reset    (i_reset),
        .in_data  (i_data),
        .in_valid (i_valid),
        .drain    (load),
        .ready    (o_ready),
        .full     (hold_full),
        .data     (hold_data)
    );

    // A new frame starts from IDLE or directly after the last stop bit.
    assign load = i_strobe && hold_full &&
                  ((state_reg == IDLE) || ((state_reg == STOP) && (stop_cnt_reg == LAST_STOP)));

    generate
        if (DATA_WIDTH > 1) begin : g_next_lsb
            assign next_lsb = shift_reg[1];
        end else begin : g_next_lsb_single
            assign next_lsb = LINE_IDLE;
        end
    endgenerate

`ifdef FRAME_SERIALIZER_PARITY_EN
    logic parity_reg;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset)
            parity_reg <= 1'b0;
        else if (load)
            parity_reg <= parity_calc(32'(hold_data), PARITY_ODD);
    end
`endif

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            shift_reg     <= '0;
            bit_cnt_reg   <= '0;
            stop_cnt_reg  <= 1'b0;
            bit_reg       <= LINE_IDLE;
            bit_valid_reg <= 1'b0;
        end else begin
            bit_valid_reg <= 1'b0;
            if (i_strobe) begin
                if (load) begin
                    state_reg     <= START;
                    shift_reg     <= hold_data;
                    bit_reg       <= START_LEVEL;
                    bit_valid_reg <= 1'b1;
                end else begin
                    case (state_reg)
                        IDLE: begin
                            bit_reg <= LINE_IDLE;
                        end
                        START: begin
                            state_reg     <= DATA;
                            bit_reg       <= shift_reg[0];
                            bit_cnt_reg   <= '0;
                            bit_valid_reg <= 1'b1;
                        end
                        DATA: begin
                            bit_valid_reg <= 1'b1;
                            if (bit_cnt_reg == LAST_BIT) begin
                                stop_cnt_reg <= 1'b0;
`ifdef FRAME_SERIALIZER_PARITY_EN
                                state_reg    <= PARITY;
                                bit_reg      <= parity_reg;
`else
                                state_reg    <= STOP;
                                bit_reg      <= LINE_IDLE;
`endif
                            end else begin
                                shift_reg   <= shift_reg >> 1;
                                bit_reg     <= next_lsb;
                                bit_cnt_reg <= bit_cnt_reg + CNT_W'(1);
                            end
                        end
`ifdef FRAME_SERIALIZER_PARITY_EN
                        PARITY: begin
                            state_reg     <= STOP;
                            bit_reg       <= LINE_IDLE;
                            stop_cnt_reg  <= 1'b0;
                            bit_valid_reg <= 1'b1;
                        end
`endif
                        STOP: begin
                            bit_reg <= LINE_IDLE;
                            if (stop_cnt_reg == LAST_STOP) begin
                                state_reg <= IDLE;
                            end else begin
                                stop_cnt_reg  <= 1'b1;
                                bit_valid_reg <= 1'b1;
                            end
                        end
                        default: state_reg <= IDLE;
                    endcase
                end
            end
        end
    end

    assign o_bit       = bit_reg;
    assign o_bit_valid = bit_valid_reg;
    assign o_busy      = (state_reg != IDLE) || hold_full;

endmodule

// File: tb/tb_frame_serializer.sv
// Directed self-checking bench for frame_serializer, strobe every 4 clocks.
// With FRAME_SERIALIZER_PARITY_EN a second odd-parity instance is checked as well.
module tb_frame_serializer;

    localparam int DW = 8;

    logic          clk      = 1'b0;
    logic          i_reset  = 1'b1;
    logic          i_strobe = 1'b0;
    logic          i_valid  = 1'b0;
    logic [DW-1:0] i_data   = '0;
    logic          o_ready, o_bit, o_bit_valid, o_busy;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int sphase      = 0;

    bit q[$];
    int tq[$];
    bit exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            sphase   = (sphase + 1) % 4;
            i_strobe = (sphase == 0);
        end
    end

`ifdef FRAME_SERIALIZER_PARITY_EN
    frame_serializer #(.DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(1'b0)) dut (
`else
    frame_serializer #(.DATA_WIDTH(DW), .STOP_BITS(1)) dut (
`endif
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_strobe    (i_strobe),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .o_bit       (o_bit),
        .o_bit_valid (o_bit_valid),
        .o_busy      (o_busy)
    );

    always @(negedge clk) begin
        if (o_bit_valid === 1'b1) begin
            q.push_back(o_bit);
            tq.push_back(cyc);
        end
    end

`ifdef FRAME_SERIALIZER_PARITY_EN
    logic o_ready_odd, o_bit_odd, o_bit_valid_odd, o_busy_odd;
    bit   qo[$];

    frame_serializer #(.DATA_WIDTH(DW), .STOP_BITS(1), .PARITY_ODD(1'b1)) dut_odd (
        .i_clk       (clk),
        .i_reset     (i_reset),
        .i_strobe    (i_strobe),
        .i_data      (i_data),
        .i_valid     (i_valid),
        .o_ready     (o_ready_odd),
        .o_bit       (o_bit_odd),
        .o_bit_valid (o_bit_valid_odd),
        .o_busy      (o_busy_odd)
    );

    always @(negedge clk) begin
        if (o_bit_valid_odd === 1'b1) qo.push_back(o_bit_odd);
    end
`endif

    // Expected line bits in transmit order for one frame of d (even parity when enabled).
    function automatic void build_frame(input logic [DW-1:0] d);
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) exp_q.push_back(d[i]);
`ifdef FRAME_SERIALIZER_PARITY_EN
        exp_q.push_back(^d);
`endif
        exp_q.push_back(1'b1);
    endfunction

    task automatic send(input logic [DW-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        i_data  = d;
        i_valid = 1'b1;
        while (o_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            vectors++; miscompares++;
            $display("FAIL send_timeout data=0x%02h ready=%b required 1", d, o_ready);
        end
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        $display("send data=0x%02h accepted at cycle %0d", d, cyc);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_after_accept actual=%b required=0", o_ready);
        end
    endtask

    task automatic wait_bits(input int n, input string name);
        int k;
        k = 0;
        while (q.size() < n && k < 300) begin
            @(negedge clk);
            k++;
        end
        if (q.size() < n) begin
            vectors++; miscompares++;
            $display("FAIL %s_timeout bits=%0d required=%0d", name, q.size(), n);
        end
    endtask

    task automatic check_frame(input string name, input int offset, input logic [DW-1:0] d);
        build_frame(d);
        for (int i = 0; i < exp_q.size(); i++) begin
            vectors++;
            if (offset + i >= q.size() || q[offset + i] !== exp_q[i]) begin
                miscompares++;
                $display("FAIL %s bit%0d actual=%b required=%b", name, i,
                         (offset + i < q.size()) ? q[offset + i] : 1'bx, exp_q[i]);
            end
        end
        $display("frame %s data=0x%02h checked", name, d);
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (o_bit !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0 || o_bit_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs actual bit=%b ready=%b busy=%b bv=%b required 1 1 0 0",
                     o_bit, o_ready, o_busy, o_bit_valid);
        end
        i_reset = 1'b0;
        q.delete(); tq.delete();
        repeat (100) @(negedge clk);
        vectors++;
        if (q.size() != 0 || o_bit !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL idle_quiet actual pulses=%0d bit=%b busy=%b required 0 1 0",
                     q.size(), o_bit, o_busy);
        end
        $display("reset and idle window checked");
    endtask

    task automatic test_single_a5();
        q.delete(); tq.delete();
        send(8'hA5);
        wait_bits(10, "a5");
        check_frame("a5", 0, 8'hA5);
        vectors++;
        if (o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL a5_busy_in_stop actual=%b required=1", o_busy);
        end
        repeat (6) @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || o_bit !== 1'b1 || q.size() != 10) begin
            miscompares++;
            $display("FAIL a5_end actual busy=%b bit=%b pulses=%0d required 0 1 10",
                     o_busy, o_bit, q.size());
        end
    endtask

    task automatic test_back_to_back();
        bit gap_ok;
        q.delete(); tq.delete();
        send(8'h3C);
        send(8'hFF);
        wait_bits(20, "b2b");
        check_frame("b2b_3c", 0, 8'h3C);
        check_frame("b2b_ff", 10, 8'hFF);
        gap_ok = (tq.size() >= 20);
        for (int i = 1; i < tq.size() && i < 20; i++)
            if (tq[i] - tq[i-1] != 4) gap_ok = 1'b0;
        vectors++;
        if (!gap_ok) begin
            miscompares++;
            $display("FAIL b2b_contiguous stop-to-start spacing actual=%0d required=4",
                     (tq.size() >= 11) ? tq[10] - tq[9] : -1);
        end
        repeat (10) @(negedge clk);
        vectors++;
        if (o_busy !== 1'b0 || q.size() != 20) begin
            miscompares++;
            $display("FAIL b2b_end actual busy=%b pulses=%0d required 0 20", o_busy, q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        q.delete(); tq.delete();
        send(8'hF0);
        send(8'h81);
        wait_bits(5, "midrst");
        vectors++;
        if (o_bit !== 1'b0 || o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_before actual bit=%b ready=%b required 0 0", o_bit, o_ready);
        end
        #2;
        i_reset = 1'b1;
        #1;
        vectors++;
        if (o_bit !== 1'b1 || o_ready !== 1'b1 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midrst_async actual bit=%b ready=%b busy=%b required 1 1 0",
                     o_bit, o_ready, o_busy);
        end
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        q.delete(); tq.delete();
        repeat (60) @(negedge clk);
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL midrst_held_discarded actual pulses=%0d required=0", q.size());
        end
        send(8'h01);
        wait_bits(10, "after_rst");
        check_frame("after_rst", 0, 8'h01);
    endtask

    task automatic test_ignored_valid();
        q.delete(); tq.delete();
        send(8'h12);
        @(negedge clk);
        vectors++;
        if (o_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_ready actual=%b required=0", o_ready);
        end
        i_data  = 8'h99;
        i_valid = 1'b1;
        @(posedge clk);
        #1;
        i_valid = 1'b0;
        $display("ignored valid pulse data=0x99 at cycle %0d", cyc);
        wait_bits(10, "ign");
        check_frame("ign", 0, 8'h12);
        repeat (80) @(negedge clk);
        vectors++;
        if (q.size() != 10 || o_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL ign_no_extra actual pulses=%0d busy=%b required 10 0", q.size(), o_busy);
        end
    endtask

`ifdef FRAME_SERIALIZER_PARITY_EN
    task automatic test_parity();
        q.delete(); tq.delete(); qo.delete();
        send(8'hA5);
        wait_bits(11, "par_a5");
        vectors++;
        if (q.size() != 11 || q[9] !== 1'b0 || qo[9] !== 1'b1) begin
            miscompares++;
            $display("FAIL par_a5 actual len=%0d even=%b odd=%b required 11 0 1",
                     q.size(), q[9], qo[9]);
        end
        repeat (8) @(negedge clk);
        q.delete(); tq.delete(); qo.delete();
        send(8'h07);
        wait_bits(11, "par_07");
        vectors++;
        if (q[9] !== 1'b1 || qo[9] !== 1'b0) begin
            miscompares++;
            $display("FAIL par_07 actual even=%b odd=%b required 1 0", q[9], qo[9]);
        end
        repeat (8) @(negedge clk);
    endtask
`endif

    initial begin
        test_reset();
        test_single_a5();
        test_back_to_back();
        test_reset_mid_frame();
        test_ignored_valid();
`ifdef FRAME_SERIALIZER_PARITY_EN
        test_parity();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
